// File: rtl/conv_window_gen.sv
// Streaming K_H x K_W sliding-window generator: raster pixels in, one registered
// window per accepted pixel whose window lies fully inside the frame.
module conv_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K_H   = 3,
    parameter int K_W   = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            pix_valid,
    input  logic [7:0]                      pix_in,
    output logic                            pix_ready,
    output logic [K_H-1:0][K_W-1:0][7:0]    img,
    output logic                            win_valid,
    output logic [$clog2(IMG_H)-1:0]        win_row,
    output logic [$clog2(IMG_W)-1:0]        win_col,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [ROW_W-1:0]               in_row_r;
    logic [COL_W-1:0]               in_col_r;
    logic                           acc_s;
    logic                           is_last_s;
    logic                           win_ok_s;
    logic [K_H-1:0][7:0]            col_s;
    logic [7:0]                     lb_r [K_H-1][IMG_W];
    logic [K_H-1:0][K_W-1:0][7:0]   win_r;
    logic                           win_valid_r;
    logic [ROW_W-1:0]               win_row_r;
    logic [COL_W-1:0]               win_col_r;
    logic                           pix_ready_r;
    logic                           busy_r;
    logic                           frame_done_r;
    logic                           pix_ready_nxt_s;
    logic                           busy_nxt_s;
    logic                           frame_done_nxt_s;

    assign acc_s     = pix_valid && pix_ready_r;
    assign is_last_s = (in_row_r == ROW_W'(IMG_H - 1)) && (in_col_r == COL_W'(IMG_W - 1));
    assign win_ok_s  = (in_row_r >= ROW_W'(K_H - 1)) && (in_col_r >= COL_W'(K_W - 1));

    assign pix_ready  = pix_ready_r;
    assign img        = win_r;
    assign win_valid  = win_valid_r;
    assign win_row    = win_row_r;
    assign win_col    = win_col_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE is entered on the edge that takes the last pixel
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_RUN;
                else       state_nxt_s = S_IDLE;
            end
            S_RUN: begin
                if (acc_s && is_last_s) state_nxt_s = S_DONE;
                else                    state_nxt_s = S_RUN;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode; frame_done/busy trail DONE by one cycle so the pulse follows the last strobe
    always_comb begin
        pix_ready_nxt_s  = 1'b0;
        busy_nxt_s       = 1'b0;
        frame_done_nxt_s = 1'b0;
        case (state_r)
            S_DONE: begin
                busy_nxt_s       = 1'b1;
                frame_done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s       = 1'b0;
                frame_done_nxt_s = 1'b0;
            end
        endcase
        if (state_nxt_s == S_RUN) begin
            pix_ready_nxt_s = 1'b1;
            busy_nxt_s      = 1'b1;
        end else begin
            pix_ready_nxt_s = 1'b0;
        end
    end

    // Registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            pix_ready_r  <= pix_ready_nxt_s;
            busy_r       <= busy_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_row_r <= {ROW_W{1'b0}};
            in_col_r <= {COL_W{1'b0}};
        end else if (state_r == S_IDLE && start) begin
            in_row_r <= {ROW_W{1'b0}};
            in_col_r <= {COL_W{1'b0}};
        end else if (acc_s) begin
            if (in_col_r == COL_W'(IMG_W - 1)) begin
                in_col_r <= {COL_W{1'b0}};
                if (is_last_s) in_row_r <= {ROW_W{1'b0}};
                else           in_row_r <= in_row_r + ROW_W'(1);
            end else begin
                in_col_r <= in_col_r + COL_W'(1);
            end
        end
    end

    // New window column: oldest buffered row on top, incoming pixel at the bottom
    always_comb begin
        col_s = '0;
        for (int i = 0; i < K_H - 1; i++) begin
            col_s[i] = lb_r[K_H-2-i][in_col_r];
        end
        col_s[K_H-1] = pix_in;
    end

    // Line buffers are never cleared; the first K_H-1 rows of a frame never form a valid window
    always_ff @(posedge clk) begin
        if (acc_s) begin
            for (int k = K_H - 2; k >= 1; k--) begin
                lb_r[k][in_col_r] <= lb_r[k-1][in_col_r];
            end
            lb_r[0][in_col_r] <= pix_in;
        end
    end

    // Window shift register and strobe/position outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r       <= '0;
            win_valid_r <= 1'b0;
            win_row_r   <= {ROW_W{1'b0}};
            win_col_r   <= {COL_W{1'b0}};
        end else begin
            win_valid_r <= acc_s && win_ok_s;
            if (acc_s) begin
                for (int i = 0; i < K_H; i++) begin
                    for (int j = 0; j < K_W - 1; j++) begin
                        win_r[i][j] <= win_r[i][j+1];
                    end
                    win_r[i][K_W-1] <= col_s[i];
                end
                if (win_ok_s) begin
                    win_row_r <= in_row_r - ROW_W'(K_H - 1);
                    win_col_r <= in_col_r - COL_W'(K_W - 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 and a default 8x8 instance share the
// pixel stream; only the started instance accepts pixels.
module tb_conv_window_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0;
    logic start8 = 1'b0;
    logic pix_valid = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic sel = 1'b0;

    logic rdy4, wv4, busy4, fd4;
    logic [2:0][2:0][7:0] img4;
    logic [1:0] row4, col4;
    logic rdy8, wv8, busy8, fd8;
    logic [2:0][2:0][7:0] img8;
    logic [2:0] row8, col8;

    logic        o_ready, o_wv, o_busy, o_fd;
    logic [71:0] o_img;
    logic [15:0] o_rc;

    int n_vec = 0;
    int n_err = 0;
    logic [71:0] wq[$];
    logic [71:0] hw[4];
    int          hsum[4];

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .K_H(3), .K_W(3)) u4 (
        .clk(clk), .rst(rst), .start(start4), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_ready(rdy4), .img(img4), .win_valid(wv4), .win_row(row4), .win_col(col4),
        .busy(busy4), .frame_done(fd4)
    );

    conv_window_gen u8 (
        .clk(clk), .rst(rst), .start(start8), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix_ready(rdy8), .img(img8), .win_valid(wv8), .win_row(row8), .win_col(col8),
        .busy(busy8), .frame_done(fd8)
    );

    assign o_ready = sel ? rdy8  : rdy4;
    assign o_wv    = sel ? wv8   : wv4;
    assign o_busy  = sel ? busy8 : busy4;
    assign o_fd    = sel ? fd8   : fd4;
    assign o_img   = sel ? img8  : img4;
    assign o_rc    = sel ? {5'd0, row8, 5'd0, col8} : {6'd0, row4, 6'd0, col4};

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int w, input int r, input int c);
        if (pat == 1) return 8'hFF;
        else          return 8'(w * r + c);
    endfunction

    function automatic logic [71:0] exp_win(input int pat, input int w, input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*8 +: 8] = pix(pat, w, r - 2 + i, c - 2 + j);
        return v;
    endfunction

    function automatic int sum9(input logic [71:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(v[i*8 +: 8]);
        return s;
    endfunction

    // Runs one frame from a negedge; returns at the negedge where frame_done is high
    // (or after the abort sequence when abort_at > 0).
    task automatic run_frame(input bit big, input int pat, input bit stall, input bit poke,
                             input int abort_at, output int strobes);
        int w, n, k, cyc, pr, pc;
        bit pacc, ev;
        w = big ? 8 : 4;
        n = w * w;
        k = 0; cyc = 0; pr = 0; pc = 0; pacc = 1'b0; strobes = 0;
        wq.delete();
        sel = big;
        if (big) start8 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start4 = 1'b0;
        check("start_ready", o_ready, 1'b1);
        check("start_busy", o_busy, 1'b1);
        while (k < n && cyc < 4000) begin
            if (pacc) begin
                ev = (pr >= 2) && (pc >= 2);
                check("win_valid", o_wv, ev);
                if (ev) begin
                    check("win_img", o_img, exp_win(pat, w, pr, pc));
                    check("win_rc", o_rc, {8'(pr - 2), 8'(pc - 2)});
                    if (o_wv) begin
                        strobes++;
                        wq.push_back(o_img);
                    end
                end
            end else begin
                check("stall_valid", o_wv, 1'b0);
            end
            check("fd_early", o_fd, 1'b0);
            if (abort_at > 0 && k == abort_at) begin
                pix_valid = 1'b0;
                #1 rst = 1'b1;
                #1;
                check("rst_ready", o_ready, 1'b0);
                check("rst_valid", o_wv, 1'b0);
                check("rst_busy", o_busy, 1'b0);
                check("rst_fd", o_fd, 1'b0);
                check("rst_img", o_img, 72'd0);
                check("rst_rc", o_rc, 16'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("abort_fd", o_fd, 1'b0);
                    check("abort_busy", o_busy, 1'b0);
                end
                return;
            end
            pix_valid = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            pix_in = pix(pat, w, k / w, k % w);
            if (big) start8 = poke && (cyc == 5); else start4 = poke && (cyc == 5);
            pacc = pix_valid && o_ready;
            if (pacc) begin
                pr = k / w;
                pc = k % w;
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        check("timeout", (cyc < 4000), 1'b1);
        pix_valid = 1'b0; start4 = 1'b0; start8 = 1'b0;
        check("last_valid", o_wv, 1'b1);
        check("last_img", o_img, exp_win(pat, w, w - 1, w - 1));
        if (o_wv) begin
            strobes++;
            wq.push_back(o_img);
        end
        check("last_fd", o_fd, 1'b0);
        check("last_ready", o_ready, 1'b0);
        @(negedge clk);
        check("done_fd", o_fd, 1'b1);
        check("done_valid", o_wv, 1'b0);
        check("done_busy", o_busy, 1'b1);
        check("done_ready", o_ready, 1'b0);
    endtask

    task automatic post_idle();
        @(negedge clk);
        check("idle_busy", o_busy, 1'b0);
        check("idle_fd", o_fd, 1'b0);
        check("idle_ready", o_ready, 1'b0);
    endtask

    initial begin
        int s;
        hw[0] = 72'h0A_09_08_06_05_04_02_01_00;
        hw[1] = 72'h0B_0A_09_07_06_05_03_02_01;
        hw[2] = 72'h0E_0D_0C_0A_09_08_06_05_04;
        hw[3] = 72'h0F_0E_0D_0B_0A_09_07_06_05;
        hsum[0] = 45; hsum[1] = 54; hsum[2] = 81; hsum[3] = 90;

        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            check("reset_ready", o_ready, 1'b0);
            check("reset_valid", o_wv, 1'b0);
            check("reset_img", o_img, 72'd0);
            check("reset_rc", o_rc, 16'd0);
            check("reset_busy", o_busy, 1'b0);
            check("reset_fd", o_fd, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4x4 full rate, then with 1,0,0,1 valid gaps
        for (int t = 0; t < 2; t++) begin
            run_frame(1'b0, 0, t[0], 1'b0, 0, s);
            check("f4_strobes", s, 4);
            check("f4_qsize", wq.size(), 4);
            for (int i = 0; i < 4 && i < wq.size(); i++) begin
                check("f4_window", wq[i], hw[i]);
                check("conv_sum", sum9(wq[i]), hsum[i]);
            end
            post_idle();
        end

        // 8x8 all-255 frame followed back-to-back by the ramp frame
        run_frame(1'b1, 1, 1'b0, 1'b0, 0, s);
        check("f8a_strobes", s, 36);
        for (int i = 0; i < wq.size(); i++) check("f8a_window", wq[i], {72{1'b1}});
        run_frame(1'b1, 0, 1'b0, 1'b0, 0, s);
        check("f8b_strobes", s, 36);
        if (wq.size() > 0) check("f8b_first", wq[0], 72'h12_11_10_0A_09_08_02_01_00);
        else               check("f8b_first_missing", wq.size(), 1);
        post_idle();

        // Reset after 20 pixels, then a clean frame
        run_frame(1'b1, 0, 1'b0, 1'b0, 20, s);
        check("abort_strobes", s, 2);
        run_frame(1'b1, 0, 1'b0, 1'b0, 0, s);
        check("after_abort_strobes", s, 36);
        post_idle();

        // pix_valid while idle, then start pulsed mid-frame
        pix_valid = 1'b1;
        pix_in = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_pv_ready", o_ready, 1'b0);
            check("idle_pv_valid", o_wv, 1'b0);
        end
        pix_valid = 1'b0;
        run_frame(1'b1, 0, 1'b0, 1'b1, 0, s);
        check("poke_strobes", s, 36);
        post_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming sliding-window generator that feeds the 3x3 convolution units. It accepts an unsigned 8-bit feature map in raster order, one pixel per handshake, and buffers the previous K_H-1 rows in line buffers. It presents every valid K_H x K_W window (stride 1, no padding) with a one-cycle `win_valid` strobe that drives the conv unit's `ready` input directly. It sits between the feature-map SRAM reader and the PE array in the NPU datapath.

## Interface

Parameters:
- IMG_W, 8, feature-map width in pixels (>= K_W)
- IMG_H, 8, feature-map height in pixels (>= K_H)
- K_H, 3, window height
- K_W, 3, window width

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- pix_valid  in  1  pixel-in-valid qualifier
- pix_in  in  8  unsigned pixel
- pix_ready  out  1  high in RUN; pixel accepted when pix_valid && pix_ready
- img  out  [7:0] x [K_H-1:0][K_W-1:0]  current window; img[0][0] is top-left
- win_valid  out  1  one-cycle strobe; img holds a complete, valid window
- win_row  out  $clog2(IMG_H)  output-map row of the presented window
- win_col  out  $clog2(IMG_W)  output-map column of the presented window
- busy  out  1  high in RUN and DONE
- frame_done  out  1  one-cycle pulse after the last window is presented

## Operation

- FSM states:
  - IDLE: `start` goes to RUN and clears the row/col counters. `pix_valid` is ignored.
  - RUN: accepts pixels. Acceptance of pixel (IMG_H-1, IMG_W-1) goes to DONE.
  - DONE: lasts one cycle, asserts `frame_done`, then returns to IDLE.
- `start` is ignored in RUN and DONE.
- Input counters: `in_col` runs 0..IMG_W-1. It wraps to 0 and increments `in_row` on acceptance at IMG_W-1.
- Line buffers: K_H-1 rows of IMG_W bytes, indexed by `in_col`.
  - On acceptance, the new window column is {linebuf[K_H-2][in_col], ..., linebuf[0][in_col], pix_in}, top to bottom.
  - linebuf[k] shifts up to linebuf[k+1] at `in_col`, and pix_in is written into linebuf[0][in_col].
  - Read and write of the same address in the same cycle return the old data.
- Window register: on acceptance, every row shifts left by one column, and the new column enters at j = K_W-1.
- Window contents: after accepting pixel (r,c), img[i][j] = pixel(r-K_H+1+i, c-K_W+1+j).
- Valid windows:
  - `win_valid` is asserted the cycle after accepting (r,c) with r >= K_H-1 and c >= K_W-1.
  - win_row = r-K_H+1, win_col = c-K_W+1.
  - Windows straddling a row wrap (c < K_W-1) never assert `win_valid`.
  - Exactly (IMG_H-K_H+1)*(IMG_W-K_W+1) strobes occur per frame.
- Gaps in `pix_valid` stall everything: window, counters and line buffers hold, and `win_valid` is 0 during the stall cycles.
- Line buffers need no clearing between frames; rows r < K_H-1 never produce valid windows.

## Timing

- Reset values: pix_ready=0, win_valid=0, img all 0, win_row=0, win_col=0, busy=0, frame_done=0, FSM in IDLE, counters 0.
- Reset mid-frame aborts immediately. No further strobes occur, and no `frame_done` is produced for the aborted frame.
- `start` sampled at edge t: RUN and `pix_ready`=1 from t+1.
- Window latency: pixel accepted at edge t gives img/win_valid/win_row/win_col valid after edge t (registered), held for one cycle.
- `img` holds its value until the next acceptance.
- Last pixel accepted at edge t:
  - last `win_valid` after t.
  - DONE with `frame_done`=1 after t+1.
  - IDLE after t+2; `start` is accepted again at edge t+2.
- Downstream: the conv unit registers its result one cycle after `win_valid`, so a full-rate stream yields one result per cycle.
- Pixel arithmetic is unsigned 8-bit pass-through; no pixel value is modified.

## Test plan

- IMG_W=IMG_H=4, pixel(r,c)=4r+c, pix_valid held high -> 4 strobes.
  - First strobe after pixel 10: img rows {0,1,2},{4,5,6},{8,9,10}, win_row=0, win_col=0.
  - Last strobe: rows {5,6,7},{9,10,11},{13,14,15}, (1,1).
  - frame_done one cycle after the last strobe.
- Same frame with pix_valid toggling 1,0,0,1 -> identical window sequence; win_valid never high during stall cycles.
- Default 8x8 frame, all pixels 255, then back-to-back second frame with pixel(r,c)=r*8+c:
  - 36 strobes per frame.
  - Frame 1 windows are all 255.
  - Frame 2 first window has rows {0,1,2},{8,9,10},{16,17,18}.
- Assert rst after 20 pixels of an 8x8 frame -> all outputs 0 asynchronously, FSM in IDLE, no frame_done. A fresh start yields a correct full frame.
- start pulsed during RUN and pix_valid driven during IDLE -> both ignored. Counters and window count are unaffected (36 windows for 8x8).
- Connect to conv_unit with all weights 1, 4x4 frame above -> results 45, 54, 81, 90, each one cycle after the corresponding win_valid.
